// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - Writeback arbiter: per-FU result FIFOs, round-robin grant, registered ROB/regfile writeback.
package wb_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [5:0]  rob_dest;
        logic [4:0]  dest;
        logic [3:0]  flags;
        logic [31:0] result;
    } cdb_t;

    typedef struct packed {
        cdb_t cdb;
    } rob_wb_t;

    typedef struct packed {
        cdb_t cdb;
        logic w_v;
    } reg_wb_t;

    localparam int ROB_WB_WIDTH = $bits(rob_wb_t);
    localparam int REG_WB_WIDTH = $bits(reg_wb_t);

endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_FU_P     = 4,
    parameter int FIFO_DEPTH_P = 4,
    parameter int SKID_P       = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  rob_wb_t [NUM_FU_P-1:0]   fu_rob_i,
    input  logic                     mispredict_i,
    output logic    [NUM_FU_P-1:0]   fu_ready_o,
    output rob_wb_t                  rob_wb_o,
    output reg_wb_t                  reg_wb_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH_P);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(NUM_FU_P);

    rob_wb_t          mem    [NUM_FU_P][FIFO_DEPTH_P];
    logic [PTR_W-1:0] rd_ptr [NUM_FU_P];
    logic [PTR_W-1:0] wr_ptr [NUM_FU_P];
    logic [CNT_W-1:0] count  [NUM_FU_P];
    logic [IDX_W-1:0] rr_ptr;

    logic             grant_v;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;
    rob_wb_t          head_pkt;
    logic [NUM_FU_P-1:0] pop;
    logic [NUM_FU_P-1:0] push;
    logic [NUM_FU_P-1:0] drop;

    // First non-empty FIFO at or after the RR pointer, wrapping modulo NUM_FU_P.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_FU_P; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(NUM_FU_P)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_FU_P);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!grant_v && (count[scan_idx] != '0)) begin
                grant_v   = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign rr_next  = (grant_idx == IDX_W'(NUM_FU_P - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign head_pkt = mem[grant_idx][rd_ptr[grant_idx]];

    // A full FIFO still accepts a push when its head is popped in the same cycle.
    always_comb begin
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < NUM_FU_P; i++) begin
            pop[i]  = grant_v && (grant_idx == IDX_W'(i));
            push[i] = fu_rob_i[i].cdb.valid &&
                      ((count[i] != CNT_W'(FIFO_DEPTH_P)) || pop[i]);
            drop[i] = fu_rob_i[i].cdb.valid && !push[i];
        end
    end

    always_comb begin
        fu_ready_o = '0;
        for (int i = 0; i < NUM_FU_P; i++) begin
            fu_ready_o[i] = (CNT_W'(FIFO_DEPTH_P) - count[i]) > CNT_W'(SKID_P);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_FU_P; i++) begin
            if (!reset_i && !mispredict_i && push[i]) begin
                mem[i][wr_ptr[i]] <= fu_rob_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_FU_P; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            rob_wb_o   <= '0;
            overflow_o <= 1'b0;
        end else if (mispredict_i) begin
            // Flush everything buffered; the RR pointer and sticky overflow survive.
            for (int i = 0; i < NUM_FU_P; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rob_wb_o.cdb.valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU_P; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
            if (|drop) begin
                overflow_o <= 1'b1;
            end
            if (grant_v) begin
                rob_wb_o           <= head_pkt;
                rob_wb_o.cdb.valid <= 1'b1;
                rr_ptr             <= rr_next;
            end else begin
                rob_wb_o.cdb.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        reg_wb_o     = '0;
        reg_wb_o.cdb = rob_wb_o.cdb;
        reg_wb_o.w_v = rob_wb_o.cdb.valid;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - Scoreboard bench for wb_arbiter with directed, hand-traced stimulus.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset_i;
    rob_wb_t [N-1:0]   fu_rob_i;
    logic              mispredict_i;
    logic [N-1:0]      fu_ready_o;
    rob_wb_t           rob_wb_o;
    reg_wb_t           reg_wb_o;
    logic              overflow_o;

    wb_arbiter #(.NUM_FU_P(N), .FIFO_DEPTH_P(4), .SKID_P(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .fu_rob_i     (fu_rob_i),
        .mispredict_i (mispredict_i),
        .fu_ready_o   (fu_ready_o),
        .rob_wb_o     (rob_wb_o),
        .reg_wb_o     (reg_wb_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        rob_wb_t pkt;
        int      cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    function automatic rob_wb_t mk(input int ph, input int fu, input int k);
        rob_wb_t p;
        p.cdb.valid    = 1'b1;
        p.cdb.rob_dest = 6'(fu * 8 + k);
        p.cdb.dest     = 5'(fu * 4 + k + ph);
        p.cdb.flags    = 4'(k);
        p.cdb.result   = 32'(ph * 4096 + fu * 256 + k);
        return p;
    endfunction

    task automatic expect_wb(input int ph, input int fu, input int k, input int c);
        exp_t e;
        e.pkt = mk(ph, fu, k);
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, req);
        end
    endtask

    // One cycle of stimulus; returns #1 after the edge that ends the cycle.
    task automatic step(input logic [N-1:0] mask, input int ph, input int k, input logic mp);
        for (int i = 0; i < N; i++) begin
            fu_rob_i[i] = mask[i] ? mk(ph, i, k) : '0;
        end
        mispredict_i = mp;
        @(posedge clk);
        #1;
        fu_rob_i     = '0;
        mispredict_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step('0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Monitor: every valid writeback must match the queue head, in the expected cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL wb_missing cyc=%0d got=none required result=%h at cyc %0d",
                     cyc, exp_q[0].pkt.cdb.result, exp_q[0].cyc);
            exp_q.delete(0);
        end
        if (rob_wb_o.cdb.valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected cyc=%0d got=%h required=none", cyc, rob_wb_o);
            end else begin
                mon_e = exp_q[0];
                exp_q.delete(0);
                if (rob_wb_o !== mon_e.pkt || mon_e.cyc != cyc ||
                    reg_wb_o.w_v !== 1'b1 || reg_wb_o.cdb !== mon_e.pkt.cdb) begin
                    bad++;
                    $display("FAIL wb_data cyc=%0d got=%h w_v=%b required=%h at cyc %0d",
                             cyc, rob_wb_o, reg_wb_o.w_v, mon_e.pkt, mon_e.cyc);
                end
            end
        end
    end

    typedef struct {
        int fu;
        int k;
        int off;
    } out_t;

    logic [N-1:0] tab_mask  [6];
    logic [N-1:0] tab_ready [6];
    out_t         tab_out   [$];
    int           base;

    initial begin
        reset_i      = 1'b1;
        fu_rob_i     = '0;
        mispredict_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;

        chk("rst_rob_wb", 64'(rob_wb_o), 64'd0);
        chk("rst_reg_wb", 64'(reg_wb_o), 64'd0);
        chk("rst_ready", 64'(fu_ready_o), 64'hF);
        chk("rst_ovf", 64'(overflow_o), 64'd0);

        // Single result from FU1: two-cycle latency.
        base = cyc;
        expect_wb(1, 1, 0, base + 2);
        step(4'b0010, 1, 0, 1'b0);
        idle(4);

        // Round-robin burst, then a second burst with the pointer back at 0.
        do_reset();
        base = cyc;
        for (int i = 0; i < N; i++) expect_wb(2, i, 0, base + 2 + i);
        for (int i = 0; i < N; i++) expect_wb(2, i, 5, base + 7 + i);
        step(4'b1111, 2, 0, 1'b0);
        idle(4);
        step(4'b1111, 2, 5, 1'b0);
        idle(6);

        // FU0 alone at one result per cycle never loses credit.
        base = cyc;
        for (int k = 0; k < 6; k++) begin
            chk("ready_fu0_solo", 64'(fu_ready_o[0]), 64'd1);
            expect_wb(3, 0, k, base + k + 2);
            step(4'b0001, 3, k, 1'b0);
        end
        idle(4);

        // All FUs contending while honouring credit.
        do_reset();
        tab_mask  = '{4'b1111, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tab_ready = '{4'b1111, 4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tab_out = '{'{0,0,2}, '{1,0,3}, '{2,0,4}, '{3,0,5}, '{0,1,6}, '{1,1,7},
                    '{2,1,8}, '{3,1,9}, '{0,2,10}, '{1,3,11}, '{2,4,12}, '{3,5,13}};
        base = cyc;
        foreach (tab_out[j]) expect_wb(4, tab_out[j].fu, tab_out[j].k, base + tab_out[j].off);
        for (int k = 0; k < 6; k++) begin
            chk("ready_contend", 64'(fu_ready_o), 64'(tab_ready[k]));
            step(tab_mask[k], 4, k, 1'b0);
        end
        idle(10);
        chk("ovf_credit_ok", 64'(overflow_o), 64'd0);

        // FU2 ignores credit; its sixth push meets a full FIFO with no pop.
        do_reset();
        tab_mask = '{4'b1111, 4'b1111, 4'b0101, 4'b0110, 4'b0100, 4'b1100};
        tab_out = '{'{0,0,2}, '{1,0,3}, '{2,0,4}, '{3,0,5}, '{0,1,6}, '{1,1,7},
                    '{2,1,8}, '{3,1,9}, '{0,2,10}, '{1,3,11}, '{2,2,12}, '{3,5,13},
                    '{2,3,14}, '{2,4,15}};
        base = cyc;
        foreach (tab_out[j]) expect_wb(5, tab_out[j].fu, tab_out[j].k, base + tab_out[j].off);
        for (int k = 0; k < 6; k++) begin
            chk("ovf_before_drop", 64'(overflow_o), 64'd0);
            step(tab_mask[k], 5, k, 1'b0);
        end
        chk("ovf_set", 64'(overflow_o), 64'd1);
        idle(12);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Reset with three entries queued and the RR pointer away from 0.
        base = cyc;
        expect_wb(6, 0, 0, base + 2);
        step(4'b0111, 6, 0, 1'b0);
        step(4'b1000, 6, 1, 1'b0);
        do_reset();
        chk("midrst_rob_wb", 64'(rob_wb_o), 64'd0);
        chk("midrst_reg_wb", 64'(reg_wb_o), 64'd0);
        chk("midrst_ready", 64'(fu_ready_o), 64'hF);
        chk("midrst_ovf", 64'(overflow_o), 64'd0);
        expect_wb(6, 0, 3, base + 5);
        expect_wb(6, 1, 3, base + 6);
        step(4'b0011, 6, 3, 1'b0);
        idle(6);

        // Mispredict flushes buffered results and same-cycle input; RR pointer (2) is kept.
        base = cyc;
        expect_wb(7, 1, 0, base + 2);
        step(4'b0010, 7, 0, 1'b0);
        step(4'b1110, 7, 1, 1'b0);
        step(4'b0001, 7, 2, 1'b1);
        chk("mp_ready", 64'(fu_ready_o), 64'hF);
        chk("mp_ovf", 64'(overflow_o), 64'd0);
        step('0, 0, 0, 1'b0);
        expect_wb(7, 3, 4, base + 6);
        expect_wb(7, 0, 4, base + 7);
        step(4'b1001, 7, 4, 1'b0);
        idle(6);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
